// File: rtl/loop_subtractor.sv
// ---------------------------------------------------------------------------
// loop_subtractor
//   Bit-serial unsigned subtractor. A start pulse latches the operands, then
//   one full-subtractor bit is evaluated per clock, LSB first, with the borrow
//   carried between cycles in a 1-bit register. After WIDTH bits the result is
//   published and done pulses for one cycle.
//
//   Optional feature: define LOOP_SUBTRACTOR_OVF_EN to add the signed-overflow
//   output ovf. The default build has no ovf port and no ovf logic.
//
// Parameters
//   WIDTH   operand/result width in bits (2..32)
//
// Ports
//   clk     sole clock, rising edge
//   rst_n   synchronous active-low reset
//   start   begin a subtraction; a and b are sampled on the same edge
//   a       minuend
//   b       subtrahend
//   busy    high while bits are being processed (RUN)
//   done    one-cycle pulse; diff/borrow (and ovf) valid
//   diff    a - b modulo 2^WIDTH, held until the next result
//   borrow  1 iff a < b (unsigned), held like diff
//   ovf     signed overflow of a - b, held like diff (LOOP_SUBTRACTOR_OVF_EN)
// ---------------------------------------------------------------------------
module loop_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef LOOP_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  // Current-bit full subtractor
  logic             ai, bi, d_bit, br_next;
  logic             load;
  logic [WIDTH-1:0] res_shift;

`ifdef LOOP_SUBTRACTOR_OVF_EN
  // Operand sign bits are kept separately because the shift registers
  // have already discarded them by the time the result is published.
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    ai        = a_sh_q[0];
    bi        = b_sh_q[0];
    d_bit     = ai ^ bi ^ br_q;
    br_next   = (~ai & bi) | (~(ai ^ bi) & br_q);
    res_shift = {d_bit, res_q[WIDTH-1:1]};
    // A new operation may start from IDLE or from the DONE cycle.
    load      = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef LOOP_SUBTRACTOR_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = res_shift;
        br_d   = br_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d  = S_DONE;
          diff_d   = res_shift;
          borrow_d = br_next;
`ifdef LOOP_SUBTRACTOR_OVF_EN
          // d_bit is the result MSB on the last bit.
          ovf_d    = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      state_d = S_RUN;
      a_sh_d  = a;
      b_sh_d  = b;
      res_d   = '0;
      br_d    = 1'b0;
      cnt_d   = '0;
`ifdef LOOP_SUBTRACTOR_OVF_EN
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef LOOP_SUBTRACTOR_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef LOOP_SUBTRACTOR_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef LOOP_SUBTRACTOR_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_loop_subtractor.sv
module tb_loop_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, borrow;
  logic [W-1:0] diff;
  logic         ovf;

  always #5 clk = ~clk;

  loop_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a_in),
    .b      (b_in),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef LOOP_SUBTRACTOR_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

`ifndef LOOP_SUBTRACTOR_OVF_EN
  assign ovf = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    int unsigned  cyc;
  } exp_t;

  exp_t         sb[$];
  int unsigned  total = 0;
  int unsigned  bad = 0;
  int unsigned  cyc = 0;
  logic         rst_at_edge = 1'b0;
  logic [W-1:0] held_diff = '0;
  logic         held_borrow = 1'b0;
  logic         held_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_at_edge = rst_n;
  end

  // Output monitor / scoreboard consumer
  always @(negedge clk) begin
    if (!rst_at_edge) begin
      chk("reset_outputs", {busy, done, borrow, ovf, diff}, '0);
      held_diff   = '0;
      held_borrow = 1'b0;
      held_ovf    = 1'b0;
    end else begin
      chk("busy_done_excl", busy & done, 1'b0);
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 want done=0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("diff", diff, e.diff);
          chk("borrow", borrow, e.borrow);
`ifdef LOOP_SUBTRACTOR_OVF_EN
          chk("ovf", ovf, e.ovf);
`endif
          chk("latency", cyc, e.cyc);
        end
        held_diff   = diff;
        held_borrow = borrow;
        held_ovf    = ovf;
      end else begin
        chk("hold", {ovf, borrow, diff}, {held_ovf, held_borrow, held_diff});
      end
    end
  end

  // Called at a negedge: drives start for one edge and registers the expectation.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ed, input logic eb, input logic eo);
    exp_t e;
    e.diff   = ed;
    e.borrow = eb;
    e.ovf    = eo;
    e.cyc    = cyc + 1 + W;
    sb.push_back(e);
    start = 1'b1;
    a_in  = av;
    b_in  = bv;
    @(negedge clk);
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
  endtask

  task automatic drain(input int unsigned budget);
    for (int unsigned i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [W-1:0] ed, output logic eb, output logic eo);
    int sd;
    ed = av - bv;
    eb = (av < bv);
    sd = int'($signed(av)) - int'($signed(bv));
    eo = (sd > 127) || (sd < -128);
  endtask

  vec_t tbl[7];

  initial begin
    logic [W-1:0] ed, av, bv;
    logic         eb, eo;
    int unsigned  k;

    tbl[0] = '{a: 8'h05, b: 8'h03, diff: 8'h02, borrow: 1'b0, ovf: 1'b0};
    tbl[1] = '{a: 8'h03, b: 8'h05, diff: 8'hFE, borrow: 1'b1, ovf: 1'b0};
    tbl[2] = '{a: 8'h00, b: 8'h00, diff: 8'h00, borrow: 1'b0, ovf: 1'b0};
    tbl[3] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, borrow: 1'b0, ovf: 1'b1};
    tbl[4] = '{a: 8'h7F, b: 8'hFF, diff: 8'h80, borrow: 1'b1, ovf: 1'b1};
    tbl[5] = '{a: 8'hFF, b: 8'hFF, diff: 8'h00, borrow: 1'b0, ovf: 1'b0};
    tbl[6] = '{a: 8'h00, b: 8'hFF, diff: 8'h01, borrow: 1'b1, ovf: 1'b0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    // First start in the first cycle after reset release
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].diff, tbl[i].borrow, tbl[i].ovf);
      drain(30);
      repeat (i % 3) @(negedge clk);
    end

    for (int i = 0; i < 12; i++) begin
      av = W'($urandom);
      bv = W'($urandom);
      model(av, bv, ed, eb, eo);
      issue(av, bv, ed, eb, eo);
      drain(30);
    end

    // start during RUN is ignored
    issue(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    a_in  = 8'hFF;
    b_in  = 8'h00;
    @(negedge clk);
    start = 1'b0;
    drain(30);
    repeat (12) @(negedge clk);

    // Back-to-back: second start in the DONE cycle
    issue(8'h20, 8'h0F, 8'h11, 1'b0, 1'b0);
    k = 0;
    while (!done && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_done_seen", done, 1'b1);
    issue(8'h01, 8'h02, 8'hFF, 1'b1, 1'b0);
    drain(30);

    // Reset mid-operation
    issue(8'h55, 8'h11, 8'h44, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("busy_before_reset", busy, 1'b1);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    // start together with reset is ignored
    start = 1'b1;
    a_in  = 8'h01;
    b_in  = 8'h02;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy, done}, 2'b00);
    issue(8'h55, 8'h11, 8'h44, 1'b0, 1'b0);
    drain(30);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
